// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM pin-level device model.
// Contents:
//   SRAM_DW, SRAM_AW  data and address widths of the board-side SRAM pins
//   ERR_RAW, ERR_TURN bit positions inside protoErr
//   rd_slot_t         one read-pipeline slot {valid, idx, data}
package sram_pkg;

    localparam int SRAM_DW  = 16;
    localparam int SRAM_AW  = 18;
    localparam int ERR_RAW  = 0;
    localparam int ERR_TURN = 1;

    typedef struct packed {
        logic               valid;
        logic [SRAM_AW-1:0] idx;
        logic [SRAM_DW-1:0] data;
    } rd_slot_t;

endpackage

// File: rtl/sram_device_model_if.sv
// Address and control pins of the external 256Kx16 SRAM.
// The data bus SRAM_DQ is bidirectional and stays a plain inout on the device.
// Modports:
//   master  SRAM controller side, drives all pins
//   slave   device model side, samples all pins
interface sram_device_model_if;

    logic [sram_pkg::SRAM_AW-1:0] SRAM_ADDR;
    logic                         SRAM_WE_N;
    logic                         SRAM_UB_N;
    logic                         SRAM_LB_N;
    logic                         SRAM_CE_N;
    logic                         SRAM_OE_N;

    modport master (
        output SRAM_ADDR, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N
    );

    modport slave (
        input  SRAM_ADDR, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N
    );

endinterface

// File: rtl/sram_rd_pipe.sv
// Read-latency shift register for the SRAM device model.
// Ports:
//   clk, rst  clock and synchronous active-high reset (clears every slot)
//   slot_i    read request captured this cycle {valid, idx, data}
//   slot_o    slot presented to the DQ drivers (slot_i itself when RD_LAT=0)
//   slots_o   all in-flight slots, used by the hazard checker (all zero when RD_LAT=0)
// Parameter RD_LAT (0..3) is the number of register stages; no stall.
module sram_rd_pipe
    import sram_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  rd_slot_t                                     slot_i,
    output rd_slot_t                                     slot_o,
    output rd_slot_t [((RD_LAT > 0) ? RD_LAT : 1)-1:0]   slots_o
);

    if (RD_LAT == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign slot_o         = slot_i;
        assign slots_o        = '0;
    end else begin : g_shift
        rd_slot_t [RD_LAT-1:0] stage_q;
        rd_slot_t [RD_LAT-1:0] stage_d;

        always_comb begin
            stage_d    = stage_q;
            stage_d[0] = slot_i;
            for (int i = 1; i < RD_LAT; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                stage_q <= '0;
            end else begin
                stage_q <= stage_d;
            end
        end

        assign slot_o  = stage_q[RD_LAT-1];
        assign slots_o = stage_q;
    end

endmodule

// File: rtl/sram_device_model.sv
// Cycle-based responder for the external 256Kx16 SRAM pins. Stores 16-bit
// words with byte lanes, returns read data after RD_LAT cycles, counts
// accesses and optionally flags pin-protocol hazards.
// Ports:
//   clk, rst   clock and synchronous active-high reset (storage is kept)
//   bus        address/control pins (slave modport)
//   SRAM_DQ    bidirectional data, driven only for an enabled lane of a valid read
//   wrCount    accepted write cycles since reset, wrapping
//   rdCount    accepted read cycles since reset, wrapping
//   protoErr   sticky hazard flags: [ERR_RAW] write hits an in-flight read,
//              [ERR_TURN] write right after the device drove DQ
// Parameters: MEM_AW storage index width (upper address bits alias),
//             RD_LAT read latency 0..3.
// Build option: define SRAM_PROTOCOL_CHECK_EN to include the hazard checker;
//               otherwise protoErr is tied to 2'b00.
module sram_device_model
    import sram_pkg::*;
#(
    parameter int MEM_AW = 10,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_device_model_if.slave   bus,
    inout  wire  [SRAM_DW-1:0]   SRAM_DQ,
    output logic [15:0]          wrCount,
    output logic [15:0]          rdCount,
    output logic [1:0]           protoErr
);

    localparam int DEPTH = 1 << MEM_AW;
    localparam int NSLOT = (RD_LAT > 0) ? RD_LAT : 1;

    logic [SRAM_DW-1:0] mem_q [DEPTH];
    logic [MEM_AW-1:0]  idx;
    logic               wr_cyc;
    logic               rd_cyc;
    logic               drv_lo;
    logic               drv_hi;
    logic [15:0]        wr_count_q, wr_count_d;
    logic [15:0]        rd_count_q, rd_count_d;
    rd_slot_t           slot_in;
    rd_slot_t           slot_out;
    rd_slot_t [NSLOT-1:0] slots;

    assign idx    = bus.SRAM_ADDR[MEM_AW-1:0];
    assign wr_cyc = ~bus.SRAM_CE_N & ~bus.SRAM_WE_N;
    assign rd_cyc = ~bus.SRAM_CE_N &  bus.SRAM_WE_N & ~bus.SRAM_OE_N;

    // Upper address bits alias onto the stored range; pipeline idx is only
    // consumed by the checker.
    logic unused_pins;
    assign unused_pins = ^{bus.SRAM_ADDR[SRAM_AW-1:MEM_AW], slot_out.idx, slots};

    // Writes are suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (!rst && wr_cyc) begin
            if (!bus.SRAM_LB_N) mem_q[idx][7:0]  <= SRAM_DQ[7:0];
            if (!bus.SRAM_UB_N) mem_q[idx][15:8] <= SRAM_DQ[15:8];
        end
    end

    always_comb begin
        wr_count_d = wr_cyc ? wr_count_q + 16'd1 : wr_count_q;
        rd_count_d = rd_cyc ? rd_count_q + 16'd1 : rd_count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count_q <= '0;
            rd_count_q <= '0;
        end else begin
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
        end
    end

    assign wrCount = wr_count_q;
    assign rdCount = rd_count_q;

    // Storage is read before any same-cycle write lands, so stage0 holds old data.
    always_comb begin
        slot_in       = '0;
        slot_in.valid = rd_cyc;
        slot_in.data  = mem_q[idx];
`ifdef SRAM_PROTOCOL_CHECK_EN
        slot_in.idx   = SRAM_AW'(idx);
`endif
    end

    sram_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .slot_i  (slot_in),
        .slot_o  (slot_out),
        .slots_o (slots)
    );

    // WE_N low means the controller owns the bus, even with OE_N still low.
    assign drv_lo = rd_cyc & ~bus.SRAM_LB_N & slot_out.valid;
    assign drv_hi = rd_cyc & ~bus.SRAM_UB_N & slot_out.valid;

    assign SRAM_DQ[7:0]  = drv_lo ? slot_out.data[7:0]  : 8'bz;
    assign SRAM_DQ[15:8] = drv_hi ? slot_out.data[15:8] : 8'bz;

`ifdef SRAM_PROTOCOL_CHECK_EN
    logic       raw_hit;
    logic       drove_q, drove_d;
    logic [1:0] err_q, err_d;

    always_comb begin
        raw_hit = 1'b0;
        for (int i = 0; i < NSLOT; i++) begin
            if (slots[i].valid && (slots[i].idx[MEM_AW-1:0] == idx)) begin
                raw_hit = 1'b1;
            end
        end
        drove_d = drv_lo | drv_hi;
        err_d   = err_q;
        if (wr_cyc && raw_hit) err_d[ERR_RAW]  = 1'b1;
        // drove_q reflects the cycle before the current one.
        if (wr_cyc && drove_q) err_d[ERR_TURN] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drove_q <= 1'b0;
            err_q   <= '0;
        end else begin
            drove_q <= drove_d;
            err_q   <= err_d;
        end
    end

    assign protoErr = err_q;
`else
    assign protoErr = 2'b00;
`endif

endmodule

// File: tb/tb_sram_device_model.sv
module tb_sram_device_model;
    import sram_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_device_model_if bus();

    tri1  [15:0] dq;
    logic        tb_drv = 1'b0;
    logic [15:0] tb_dq  = 16'h0000;
    assign dq = tb_drv ? tb_dq : 16'bz;

    logic [15:0] wr_count;
    logic [15:0] rd_count;
    logic [1:0]  proto_err;

    sram_device_model #(
        .MEM_AW (10),
        .RD_LAT (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .SRAM_DQ  (dq),
        .wrCount  (wr_count),
        .rdCount  (rd_count),
        .protoErr (proto_err)
    );

`ifdef SRAM_PROTOCOL_CHECK_EN
    localparam logic [1:0] EXP_HAZARD = 2'b11;
`else
    localparam logic [1:0] EXP_HAZARD = 2'b00;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        ce_n, we_n, oe_n, ub_n, lb_n;
        logic [17:0] addr;
        logic        drv;
        logic [15:0] wdata;
        logic        chk_dq;
        logic [15:0] exp_dq;
        logic [15:0] exp_wr;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t wr_v(logic [17:0] a, logic [15:0] d, logic ub, logic lb,
                                  logic [15:0] ew, logic [15:0] er);
        vec_t v;
        v = '{ce_n:1'b0, we_n:1'b0, oe_n:1'b1, ub_n:ub, lb_n:lb, addr:a, drv:1'b1,
              wdata:d, chk_dq:1'b0, exp_dq:16'h0, exp_wr:ew, exp_rd:er};
        return v;
    endfunction

    function automatic vec_t rd_v(logic [17:0] a, logic ub, logic lb, logic [15:0] ed,
                                  logic [15:0] ew, logic [15:0] er);
        vec_t v;
        v = '{ce_n:1'b0, we_n:1'b1, oe_n:1'b0, ub_n:ub, lb_n:lb, addr:a, drv:1'b0,
              wdata:16'h0, chk_dq:1'b1, exp_dq:ed, exp_wr:ew, exp_rd:er};
        return v;
    endfunction

    function automatic vec_t idle_v(logic [15:0] ew, logic [15:0] er);
        vec_t v;
        v = '{ce_n:1'b1, we_n:1'b1, oe_n:1'b1, ub_n:1'b1, lb_n:1'b1, addr:18'h0, drv:1'b0,
              wdata:16'h0, chk_dq:1'b1, exp_dq:16'hFFFF, exp_wr:ew, exp_rd:er};
        return v;
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pins(logic ce_n, logic we_n, logic oe_n, logic ub_n, logic lb_n,
                            logic [17:0] a, logic drv, logic [15:0] d);
        bus.SRAM_CE_N = ce_n;
        bus.SRAM_WE_N = we_n;
        bus.SRAM_OE_N = oe_n;
        bus.SRAM_UB_N = ub_n;
        bus.SRAM_LB_N = lb_n;
        bus.SRAM_ADDR = a;
        tb_drv        = drv;
        tb_dq         = d;
    endtask

    initial begin
        set_pins(1, 1, 1, 1, 1, 18'h0, 0, 16'h0);

        vecs.push_back(wr_v(18'h00040, 16'hBEEF, 0, 0, 1, 0));
        vecs.push_back(rd_v(18'h00040, 0, 0, 16'hBEEF, 1, 1));
        vecs.push_back(wr_v(18'h00041, 16'h1234, 0, 0, 2, 1));
        vecs.push_back(wr_v(18'h00041, 16'hABCD, 0, 1, 3, 1));
        vecs.push_back(rd_v(18'h00041, 0, 0, 16'hAB34, 3, 2));
        vecs.push_back(wr_v(18'h00010, 16'h000A, 0, 0, 4, 2));
        vecs.push_back(wr_v(18'h00011, 16'h000B, 0, 0, 5, 2));
        vecs.push_back(wr_v(18'h00012, 16'h000C, 0, 0, 6, 2));
        vecs.push_back(rd_v(18'h00010, 1, 0, 16'hFF0A, 6, 3));
        vecs.push_back(rd_v(18'h00011, 1, 0, 16'hFF0B, 6, 4));
        vecs.push_back(rd_v(18'h00012, 1, 0, 16'hFF0C, 6, 5));
        vecs.push_back(idle_v(6, 5));
        vecs.push_back(wr_v(18'h00400, 16'h5A5A, 0, 0, 7, 5));
        vecs.push_back(rd_v(18'h00000, 0, 0, 16'h5A5A, 7, 6));
        vecs.push_back(idle_v(7, 6));
        vecs.push_back(wr_v(18'h00000, 16'h1111, 1, 1, 8, 6));
        vecs.push_back(rd_v(18'h00000, 0, 0, 16'h5A5A, 8, 7));
        vecs.push_back(rd_v(18'h00040, 1, 1, 16'hFFFF, 8, 8));
        vecs.push_back(rd_v(18'h00040, 0, 0, 16'hBEEF, 8, 9));
        vecs.push_back(idle_v(8, 9));

        // reset
        tick();
        tick();
        rst = 1'b0;
        check("reset_dq", dq, 16'hFFFF);
        check("reset_wr", wr_count, 16'd0);
        check("reset_rd", rd_count, 16'd0);
        check("reset_err", {14'd0, proto_err}, 16'd0);

        foreach (vecs[i]) begin
            set_pins(vecs[i].ce_n, vecs[i].we_n, vecs[i].oe_n, vecs[i].ub_n, vecs[i].lb_n,
                     vecs[i].addr, vecs[i].drv, vecs[i].wdata);
            tick();
            if (vecs[i].chk_dq) check($sformatf("vec%0d_dq", i), dq, vecs[i].exp_dq);
            check($sformatf("vec%0d_wr", i), wr_count, vecs[i].exp_wr);
            check($sformatf("vec%0d_rd", i), rd_count, vecs[i].exp_rd);
            check($sformatf("vec%0d_err", i), {14'd0, proto_err}, 16'd0);
        end

        // read 0x20 held two cycles, then write 0x20 straight after
        set_pins(0, 1, 0, 0, 0, 18'h00020, 0, 16'h0);
        tick();
        tick();
        set_pins(0, 0, 0, 0, 0, 18'h00020, 0, 16'h0);
        #1;
        check("we_low_no_drive", dq, 16'hFFFF);
        tb_drv = 1'b1;
        tb_dq  = 16'h7777;
        tick();
        check("hazard_err", {14'd0, proto_err}, {14'd0, EXP_HAZARD});
        check("hazard_wr", wr_count, 16'd9);
        check("hazard_rd", rd_count, 16'd11);
        set_pins(1, 1, 1, 1, 1, 18'h0, 0, 16'h0);
        tick();

        // reset with a read in flight, then reset during a write
        set_pins(0, 1, 0, 0, 0, 18'h00040, 0, 16'h0);
        tick();
        check("pre_rst_dq", dq, 16'hBEEF);
        rst = 1'b1;
        tick();
        check("rst_read_dq", dq, 16'hFFFF);
        check("rst_wr", wr_count, 16'd0);
        check("rst_rd", rd_count, 16'd0);
        check("rst_err", {14'd0, proto_err}, 16'd0);
        set_pins(0, 0, 1, 0, 0, 18'h00040, 1, 16'h0000);
        tick();
        rst = 1'b0;
        set_pins(0, 1, 0, 0, 0, 18'h00040, 0, 16'h0);
        #1;
        check("reread_latency_dq", dq, 16'hFFFF);
        tick();
        check("reread_dq", dq, 16'hBEEF);
        check("reread_wr", wr_count, 16'd0);
        check("reread_rd", rd_count, 16'd1);
        set_pins(1, 1, 1, 1, 1, 18'h0, 0, 16'h0);
        tick();

        // write counter wrap with lane-less writes
        set_pins(0, 0, 1, 1, 1, 18'h00000, 0, 16'h0);
        repeat (65535) tick();
        check("wrap_ffff", wr_count, 16'hFFFF);
        tick();
        check("wrap_zero", wr_count, 16'h0000);
        check("wrap_rd", rd_count, 16'd1);
        set_pins(1, 1, 1, 1, 1, 18'h0, 0, 16'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
